id_imm_sched: RTL
=================

ID_IMM_SCHED -- requirements
Module: id_imm_sched

Interface
REQ-001 Parameter STALL_CNT_W, default 16, width of stall-cycle statistics counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  IF stage presents an instruction.
REQ-005 in_ready  output  1  block accepts the instruction this cycle.
REQ-006 in_inst  input  32  MIPS instruction word.
REQ-007 in_pc  input  32  instruction address.
REQ-008 flush  input  1  synchronous pipeline flush; discards all held entries.
REQ-009 out_valid  output  1  EX-stage entry available.
REQ-010 out_ready  input  1  EX stage consumes the entry this cycle.
REQ-011 out_imm32  output  32  extended immediate.
REQ-012 out_ext_sel  output  2  extension mode used: 00 sign, 01 zero, 10 shamt, 11 upper.
REQ-013 out_use_imm  output  1  ALU operand B takes out_imm32.
REQ-014 out_pc  output  32  PC of the presented entry.
REQ-015 stall_cnt  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-016 Decode SHALL use opcode in_inst[31:26], funct in_inst[5:0], shamt in_inst[10:6], imm16 in_inst[15:0].
REQ-017 Opcode 000000 with funct 000000/000010/000011 (SLL/SRL/SRA): ext_sel=10, imm32={27'b0,shamt}, use_imm=1.
REQ-018 ANDI 001100, ORI 001101, XORI 001110: ext_sel=01, imm32={16'b0,imm16}, use_imm=1.
REQ-019 ADDI/ADDIU/SLTI/SLTIU (0010xx), loads (100xxx), stores (101xxx): ext_sel=00, sign-extended imm16, use_imm=1.
REQ-020 Branches 0001xx: ext_sel=00, sign-extended imm16, use_imm=0.
REQ-021 LUI 001111: per REQ-033.
REQ-022 Any other encoding: ext_sel=00, imm32=0, use_imm=0.
REQ-023 Buffering SHALL be a 2-entry FIFO-ordered skid buffer, states EMPTY, ONE, TWO; in_ready = (state != TWO), combinational from state only.
REQ-024 Accept = in_valid & in_ready; pop = out_valid & out_ready; out_valid = (state != EMPTY); outputs driven from head-entry registers.
REQ-025 Transitions: EMPTY+accept->ONE; ONE+accept&!pop->TWO; ONE+pop&!accept->EMPTY; ONE+accept&pop->ONE (new entry becomes head); TWO+pop->ONE; otherwise hold.
REQ-026 Latency: instruction accepted in cycle N SHALL appear on outputs in cycle N+1 when buffer was EMPTY or head popped in cycle N.
REQ-027 Order SHALL be preserved; no entry dropped or duplicated except by flush.
REQ-028 flush=1 forces state EMPTY next cycle, overriding simultaneous accept and pop; input that cycle is discarded.
REQ-029 Head outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-030 stall_cnt increments by 1 each cycle out_valid&!out_ready, saturates at all-ones, unaffected by flush.

Reset
REQ-031 resetn=0 SHALL immediately force state EMPTY, out_valid=0, in_ready=0 while asserted, stall_cnt=0, out_imm32/out_pc=0, out_ext_sel=00, out_use_imm=0.
REQ-032 Reset mid-transfer SHALL discard all held entries; in_ready=1 the first cycle after deassertion.

Configuration
REQ-033 Macro LUI_UPPER_EN: defined -> LUI yields ext_sel=11, imm32={imm16,16'b0}, use_imm=1; undefined -> LUI yields ext_sel=01, zero-extended imm16, use_imm=1 (EX shifts), ext_sel=11 never produced.

Structure
REQ-034 Shared package holds opcode/funct constants, ext_sel encodings (EXT_SIGN, EXT_ZERO, EXT_SHAMT, EXT_UPPER) and buffer state encodings.
REQ-035 Combinational decode+extend SHALL be sub-module imm_decode (in_inst -> ext_sel, imm32, use_imm); id_imm_sched holds buffer, FSM and counter.

Verification
REQ-036 ORI inst 0x3421_8001, buffer empty, out_ready=1 -> next cycle out_imm32=0x0000_8001, ext_sel=01, use_imm=1.
REQ-037 ADDIU imm16 0xFFFC then SRA shamt 5 back-to-back -> out_imm32 0xFFFF_FFFC (sel 00) then 0x0000_0005 (sel 10), in order.
REQ-038 out_ready=0 for 5 cycles, 3 inputs offered -> 2 accepted, in_ready=0 after second, head stable, stall_cnt=5; then drain both in order.
REQ-039 State TWO with flush and in_valid same cycle -> next cycle out_valid=0, in_ready=1, input discarded.
REQ-040 LUI imm16 0x1234 -> with LUI_UPPER_EN 0x1234_0000 sel 11; without 0x0000_1234 sel 01.
REQ-041 resetn asserted asynchronously while state TWO -> outputs zero same cycle, stall_cnt=0.

Source files
------------

// File: rtl/id_imm_sched_pkg.sv
// Shared constants and types for the ID-stage immediate scheduler.
// Opcode/funct codes, ext_sel encodings, buffer states, entry bundle.
package id_imm_sched_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_SHAMT = 2'b10;
  localparam logic [1:0] EXT_UPPER = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic [31:0] imm32;
    logic [1:0]  ext_sel;
    logic        use_imm;
    logic [31:0] pc;
  } imm_ent_t;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_imm_sched_imm_decode.sv
// imm_decode: combinational immediate select and extension.
// Ports: inst in; ext_sel, imm32, use_imm out. Macro: LUI_UPPER_EN.
module imm_decode
  import id_imm_sched_pkg::*;
(
  input  logic [31:0] inst,
  output logic [1:0]  ext_sel,
  output logic [31:0] imm32,
  output logic        use_imm
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  sh;
  logic [15:0] imm;
  logic        is_shift;
  logic        is_logic;
  logic        is_lui;
  logic        is_arith;
  logic        is_br;

  assign op  = inst[31:26];
  assign fn  = inst[5:0];
  assign sh  = inst[10:6];
  assign imm = inst[15:0];

  assign is_shift = (op == OP_SPECIAL) &&
                    ((fn == FN_SLL) ||
                     (fn == FN_SRL) ||
                     (fn == FN_SRA));
  assign is_logic = (op == OP_ANDI) ||
                    (op == OP_ORI)  ||
                    (op == OP_XORI);
  assign is_lui   = (op == OP_LUI);
  // 0010xx arith-imm, 100xxx loads, 101xxx stores
  assign is_arith = (op[5:2] == 4'b0010) ||
                    (op[5:4] == 2'b10);
  assign is_br    = (op[5:2] == 4'b0001);

  always_comb begin
    ext_sel = EXT_SIGN;
    imm32   = '0;
    use_imm = 1'b0;
    unique case (1'b1)
      is_shift: begin
        ext_sel = EXT_SHAMT;
        imm32   = {27'b0, sh};
        use_imm = 1'b1;
      end
      is_logic: begin
        ext_sel = EXT_ZERO;
        imm32   = {16'b0, imm};
        use_imm = 1'b1;
      end
      is_lui: begin
`ifdef LUI_UPPER_EN
        ext_sel = EXT_UPPER;
        imm32   = {imm, 16'b0};
`else
        // EX stage performs the 16-bit shift
        ext_sel = EXT_ZERO;
        imm32   = {16'b0, imm};
`endif
        use_imm = 1'b1;
      end
      is_arith: begin
        imm32   = sext16(imm);
        use_imm = 1'b1;
      end
      is_br: begin
        imm32   = sext16(imm);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_imm_sched.sv
// id_imm_sched: immediate decode plus 2-entry skid buffer to EX.
// Ports: in_* handshake from IF, out_* to EX, flush, stall_cnt.
module id_imm_sched
  import id_imm_sched_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [31:0]            in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_imm32,
  output logic [1:0]             out_ext_sel,
  output logic                   out_use_imm,
  output logic [31:0]            out_pc,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  buf_state_t state;
  imm_ent_t   head;
  imm_ent_t   tail;
  imm_ent_t   new_ent;
  logic [1:0]  dec_sel;
  logic [31:0] dec_imm;
  logic        dec_use;
  logic        accept;
  logic        pop;

  imm_decode u_dec (
    .inst    (in_inst),
    .ext_sel (dec_sel),
    .imm32   (dec_imm),
    .use_imm (dec_use)
  );

  assign new_ent = '{imm32:   dec_imm,
                     ext_sel: dec_sel,
                     use_imm: dec_use,
                     pc:      in_pc};

  // Held low during reset so IF cannot push into a cleared buffer
  assign in_ready  = resetn & (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_imm32   = head.imm32;
  assign out_ext_sel = head.ext_sel;
  assign out_use_imm = head.use_imm;
  assign out_pc      = head.pc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) begin
            head  <= new_ent;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head <= new_ent;
          end else if (accept) begin
            tail  <= new_ent;
            state <= ST_TWO;
          end else if (pop) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head  <= tail;
            state <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready &&
                 (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule
